// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package rf_ctrl_pkg;
    localparam int RF_N = 5;
    localparam int RF_M = 32;

    typedef struct packed {
        logic [RF_N-1:0] rd;
        logic [RF_M-1:0] wd;
    } wb_req_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } starve_state_e;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency writeback requests {rd, wd}.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full is evaluated before any same-cycle pop, so a full FIFO never accepts.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and buffered
// long-latency results; tracks busy destinations and forces a stall if the FIFO starves.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N      = RF_N,
    parameter int M      = RF_M,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pipe_we,
    input  logic [N-1:0] pipe_rd,
    input  logic [M-1:0] pipe_wd,
    output logic         pipe_stall,
    input  logic         lu_valid,
    output logic         lu_ready,
    input  logic [N-1:0] lu_rd,
    input  logic [M-1:0] lu_wd,
    input  logic         issue_valid,
    input  logic [N-1:0] issue_rd,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic         raw_hazard,
    output logic         waw_hazard,
    output logic         rf_we,
    output logic [N-1:0] rf_a3,
    output logic [M-1:0] rf_wd,
    output logic         dbg_state_o
);
    localparam int NREG = 1 << N;
    localparam int CW   = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE - 1);

    // LLU handshake: a result transfers on a posedge where lu_valid && lu_ready.
    logic           ready_q;
    logic           fifo_full, fifo_empty, push, pop;
    logic [N+M-1:0] head_flat;
    logic [N-1:0]   head_rd;
    logic [M-1:0]   head_wd;
    logic [NREG-1:0] busy_q, busy_d;
    starve_state_e  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           starve_cond;

    assign {head_rd, head_wd} = head_flat;
    assign lu_ready = ready_q && !fifo_full;
    assign push     = lu_valid && lu_ready;
    assign pop      = !pipe_we && !fifo_empty;

    wb_fifo #(.W(N + M), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({lu_rd, lu_wd}),
        .pop_i       (pop),
        .head_o      (head_flat),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (pipe_we) begin
            rf_we = (pipe_rd != '0);
            rf_a3 = pipe_rd;
            rf_wd = pipe_wd;
        end else if (!fifo_empty) begin
            rf_we = (head_rd != '0);
            rf_a3 = head_rd;
            rf_wd = head_wd;
        end
    end

    // A new issue to the register being retired this cycle must stay busy: set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop)         busy_d[head_rd]  = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign raw_hazard = busy_q[rs1] | busy_q[rs2];
    assign waw_hazard = busy_q[issue_rd];

    assign starve_cond = pipe_we && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (starve_cond) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STALL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            STALL: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign pipe_stall  = (state_q == STALL);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            busy_q  <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            busy_q  <= busy_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    a_no_we_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
        pipe_stall |-> !pipe_we);
    // Re-issuing the register that retires in this same cycle is legal.
    a_no_waw_issue: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid |-> (!waw_hazard || (pop && head_rd == issue_rd)));
    a_pipe_rd_free: assert property (@(posedge clk) disable iff (!rst_n)
        pipe_we |-> !busy_q[pipe_rd]);
    a_lu_rd_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (lu_valid && lu_rd != '0) |-> busy_q[lu_rd]);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed table, multi-cycle corner sequences, randomized run.
module tb_rf_wb_arbiter;
  localparam int N = 5;
  localparam int M = 32;
  localparam int DEPTH = 2;
  localparam int STARVE = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pipe_we, pipe_stall, lu_valid, lu_ready, issue_valid;
  logic [N-1:0] pipe_rd, lu_rd, issue_rd, rs1, rs2, rf_a3;
  logic [M-1:0] pipe_wd, lu_wd, rf_wd;
  logic         raw_hazard, waw_hazard, rf_we, dbg_state;

  int n_tests = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.N(N), .M(M), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .raw_hazard(raw_hazard), .waw_hazard(waw_hazard),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    lu_valid = 0; lu_rd = 0; lu_wd = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic check_port(input string name, input logic we, input logic [N-1:0] a3,
                            input logic [M-1:0] wd);
    check({name, ".rf_we"}, rf_we, we);
    check({name, ".rf_a3"}, rf_a3, a3);
    check({name, ".rf_wd"}, rf_wd, wd);
  endtask

  typedef struct packed {
    logic         pipe_we;
    logic [N-1:0] pipe_rd;
    logic [M-1:0] pipe_wd;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic [N-1:0] issue_rd;
    logic         exp_we;
    logic [N-1:0] exp_a3;
    logic [M-1:0] exp_wd;
    logic         exp_raw;
    logic         exp_waw;
  } vec_t;

  vec_t tbl[5];

  // scoreboard for the randomized phase
  logic [N+M-1:0] exp_q[$];
  logic [N-1:0]   out_q[$];
  bit             m_busy[32];
  bit             m_stall;
  int             consec;

  initial begin
    logic [N-1:0]   r;
    logic [N+M-1:0] head;
    logic           e_we, e_ready, pushed, popped, lu_taken;
    logic [N-1:0]   e_a3;
    logic [M-1:0]   e_wd;
    int             size_before;

    tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  5'd1,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    tbl[1] = '{1'b1, 5'd5,  32'h1234,     5'd0,  5'd7,  5'd7,  1'b1, 5'd5,  32'h1234,     1'b1, 1'b1};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFF,     5'd3,  5'd4,  5'd0,  1'b0, 5'd0,  32'hFFFF,     1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0};

    // 1: reset holds lu_ready low even with lu_valid driven
    drive_idle();
    rst_n = 0;
    lu_valid = 1;
    @(negedge clk); #1;
    check("rst.lu_ready", lu_ready, 0);
    check("rst.rf_we", rf_we, 0);
    check("rst.pipe_stall", pipe_stall, 0);
    @(negedge clk);
    rst_n = 1;
    lu_valid = 0;
    next_cycle(); #1;
    check("rel.lu_ready", lu_ready, 1);
    check_port("rel", 0, 0, 0);

    // table: mux and hazards with busy[7] set, FIFO empty
    next_cycle(); issue_valid = 1; issue_rd = 7;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      pipe_we = tbl[i].pipe_we; pipe_rd = tbl[i].pipe_rd; pipe_wd = tbl[i].pipe_wd;
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; issue_rd = tbl[i].issue_rd;
      #1;
      check_port($sformatf("tbl%0d", i), tbl[i].exp_we, tbl[i].exp_a3, tbl[i].exp_wd);
      check($sformatf("tbl%0d.raw", i), raw_hazard, tbl[i].exp_raw);
      check($sformatf("tbl%0d.waw", i), waw_hazard, tbl[i].exp_waw);
    end

    // 2: LLU result for rd 7, written one cycle after acceptance
    next_cycle(); lu_valid = 1; lu_rd = 7; lu_wd = 32'hDEADBEEF; #1;
    check("t2.ready", lu_ready, 1);
    check("t2.nobypass", rf_we, 0);
    next_cycle(); rs1 = 7; #1;
    check_port("t2.wr", 1, 7, 32'hDEADBEEF);
    check("t2.raw_before", raw_hazard, 1);
    next_cycle(); rs1 = 7; #1;
    check("t2.raw_after", raw_hazard, 0);
    check("t2.idle", rf_we, 0);

    // 3: starvation forces a one-cycle stall after STARVE pipe wins
    next_cycle(); issue_valid = 1; issue_rd = 3;
    next_cycle(); lu_valid = 1; lu_rd = 3; lu_wd = 32'h33;
    pipe_we = 1; pipe_rd = 5; pipe_wd = 32'h55; #1;
    check_port("t3.push", 1, 5, 32'h55);
    for (int i = 0; i < STARVE; i++) begin
      next_cycle(); pipe_we = 1; pipe_rd = 5; pipe_wd = 32'h55 + i; #1;
      check($sformatf("t3.nostall%0d", i), pipe_stall, 0);
      check_port($sformatf("t3.pipe%0d", i), 1, 5, 32'h55 + i);
    end
    next_cycle(); #1;
    check("t3.stall", pipe_stall, 1);
    check("t3.dbg", dbg_state, 1);
    check_port("t3.drain", 1, 3, 32'h33);
    next_cycle(); rs1 = 3; #1;
    check("t3.unstall", pipe_stall, 0);
    check("t3.raw", raw_hazard, 0);
    check("t3.empty", rf_we, 0);

    // 4: full FIFO back-pressures the LLU until a pop
    for (int i = 10; i < 13; i++) begin
      next_cycle(); issue_valid = 1; issue_rd = 5'(i);
    end
    for (int i = 10; i < 12; i++) begin
      next_cycle(); pipe_we = 1; pipe_rd = 5; lu_valid = 1; lu_rd = 5'(i); lu_wd = 32'(i * 16);
    end
    next_cycle(); pipe_we = 1; pipe_rd = 5; lu_valid = 1; lu_rd = 12; lu_wd = 32'hC0; #1;
    check("t4.full", lu_ready, 0);
    next_cycle(); lu_valid = 1; lu_rd = 12; lu_wd = 32'hC0; #1;
    check("t4.full_prepop", lu_ready, 0);
    check_port("t4.pop10", 1, 10, 32'hA0);
    next_cycle(); lu_valid = 1; lu_rd = 12; lu_wd = 32'hC0; #1;
    check("t4.accept", lu_ready, 1);
    check_port("t4.pop11", 1, 11, 32'hB0);
    next_cycle(); #1;
    check_port("t4.pop12", 1, 12, 32'hC0);
    next_cycle(); #1;
    check_port("t4.empty", 0, 0, 0);

    // 5: x0 writes from both sources consume cycle/slot without rf_we
    next_cycle(); lu_valid = 1; lu_rd = 0; lu_wd = 32'h77; pipe_we = 1; pipe_rd = 0; pipe_wd = 32'h88; #1;
    check("t5.pipe_x0", rf_we, 0);
    next_cycle(); rs1 = 0; #1;
    check_port("t5.lu_x0", 0, 0, 32'h77);
    check("t5.raw0", raw_hazard, 0);
    next_cycle(); pipe_we = 1; pipe_rd = 1; lu_valid = 1; lu_rd = 0; #1;
    check("t5.slot_free", lu_ready, 1);
    next_cycle(); pipe_we = 1; pipe_rd = 1; lu_valid = 1; lu_rd = 0; #1;
    check("t5.one_slot_left", lu_ready, 1);
    next_cycle(); pipe_we = 1; pipe_rd = 1; #1;
    check("t5.full", lu_ready, 0);
    next_cycle();
    next_cycle(); #1;
    check("t5.drained", lu_ready, 1);

    // 6: same-cycle retire and re-issue of rd 9, then reset mid-fill
    next_cycle(); issue_valid = 1; issue_rd = 9;
    next_cycle(); lu_valid = 1; lu_rd = 9; lu_wd = 32'h99;
    next_cycle(); issue_valid = 1; issue_rd = 9; #1;
    check_port("t6.pop9", 1, 9, 32'h99);
    next_cycle(); rs1 = 9; #1;
    check("t6.setwins", raw_hazard, 1);
    next_cycle(); issue_valid = 1; issue_rd = 20;
    next_cycle(); pipe_we = 1; pipe_rd = 5; lu_valid = 1; lu_rd = 20; lu_wd = 32'h2020;
    next_cycle(); rst_n = 0; rs1 = 9; rs2 = 20; #1;
    check("t6.rst_ready", lu_ready, 0);
    check("t6.rst_we", rf_we, 0);
    check("t6.rst_busy", raw_hazard, 0);
    next_cycle(); rst_n = 1;
    next_cycle(); rs1 = 9; rs2 = 20; #1;
    check("t6.rel_ready", lu_ready, 1);
    check_port("t6.fifo_empty", 0, 0, 0);
    check("t6.rel_busy", raw_hazard, 0);

    // randomized run against the scoreboard
    exp_q.delete(); out_q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_stall = 0; consec = 0; lu_taken = 0;
    drive_idle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (lu_taken) lu_valid = 0;
      lu_taken = 0;
      r = 5'($urandom_range(0, 31));
      pipe_rd = r; pipe_wd = $urandom;
      pipe_we = !m_stall && ($urandom_range(0, 99) < 60) && !m_busy[r];
      r = 5'($urandom_range(0, 31));
      issue_rd = r;
      issue_valid = ($urandom_range(0, 99) < 30) && !m_busy[r];
      if (!lu_valid) begin
        if (out_q.size() > 0 && $urandom_range(0, 99) < 50) begin
          lu_valid = 1; lu_rd = out_q.pop_front(); lu_wd = $urandom;
        end else if ($urandom_range(0, 99) < 5) begin
          lu_valid = 1; lu_rd = 0; lu_wd = $urandom;
        end
      end
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1;
      size_before = exp_q.size();
      if (pipe_we) begin
        e_we = (pipe_rd != 0); e_a3 = pipe_rd; e_wd = pipe_wd;
      end else if (size_before > 0) begin
        head = exp_q[0];
        e_a3 = head[N+M-1:M]; e_wd = head[M-1:0]; e_we = (e_a3 != 0);
      end else begin
        e_we = 0; e_a3 = 0; e_wd = 0;
      end
      e_ready = (size_before < DEPTH);
      check_port("rnd", e_we, e_a3, e_wd);
      check("rnd.lu_ready", lu_ready, e_ready);
      check("rnd.pipe_stall", pipe_stall, m_stall);
      check("rnd.raw", raw_hazard, m_busy[rs1] | m_busy[rs2]);
      check("rnd.waw", waw_hazard, m_busy[issue_rd]);

      pushed = lu_valid && e_ready;
      popped = !pipe_we && size_before > 0;
      if (popped) begin
        head = exp_q.pop_front();
        m_busy[head[N+M-1:M]] = 0;
      end
      if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1;
        out_q.push_back(issue_rd);
      end
      if (pushed) begin
        exp_q.push_back({lu_rd, lu_wd});
        lu_taken = 1;
      end
      if (m_stall) begin
        m_stall = 0; consec = 0;
      end else if (pipe_we && size_before > 0) begin
        consec++;
        if (consec == STARVE) begin
          m_stall = 1; consec = 0;
        end
      end else begin
        consec = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
